// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch unit
// Contents: fetch_state_t (IDLE/RUN/FAULT), fetch_entry_t {pc, instr}, IFETCH_BUF_DEPTH.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int IFETCH_BUF_DEPTH = 2;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry flushable FIFO of fetched {pc, instr} words
// Ports: clk, rst (sync, active-high); push/push_entry write; pop advances head;
//        flush empties (wins over push); count = occupancy; head = oldest entry.
module fetch_buffer
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [IFETCH_BUF_DEPTH];
  fetch_entry_t mem_d [IFETCH_BUF_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok, push_ok;

  // Guard against pops of an empty buffer and pushes into a full one
  // that is not draining this cycle.
  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q < 2'(IFETCH_BUF_DEPTH)) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, imem read port driver and two-deep fetch buffer to decode
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_data combinational read port;
//        redirect_valid/redirect_pc from execute; if_valid/if_ready/if_instr/if_pc to decode;
//        fetch_fault sticky fault flag.
// Optional feature macro: IFETCH_BOUNDS_CHECK_EN (stop fetching past IMEM_BYTES).
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         pop;
  logic         oob;

`ifdef IFETCH_BOUNDS_CHECK_EN
  // 33-bit sum so a PC near the top of the address space cannot wrap into range.
  logic [32:0] last_byte;
  assign last_byte = {1'b0, pc_q} + 33'd3;
  assign oob       = (state_q == RUN) && (last_byte > 33'(IMEM_BYTES - 1));
`else
  assign oob = 1'b0;
`endif

  assign if_valid  = (count != 2'd0);
  assign pop       = if_valid && if_ready;
  assign imem_addr = pc_q;
  // A pop this cycle frees a slot, so a full buffer can still accept a fetch.
  assign imem_req  = (state_q == RUN) && !redirect_valid && !oob &&
                     ((count < 2'(IFETCH_BUF_DEPTH)) || pop);

  assign push_entry = '{pc: pc_q, instr: imem_data};

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (imem_req),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      // Misaligned targets are still latched into the PC for debug visibility.
      pc_d = redirect_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        state_d = RUN;
        fault_d = 1'b0;
      end else begin
        state_d = FAULT;
        fault_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (oob) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else if (imem_req) begin
            pc_d = pc_q + 32'd4;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign if_instr    = if_valid ? head.instr : 32'h0;
  assign if_pc       = if_valid ? head.pc    : 32'h0;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (128)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      default: return 32'hA000_0000 ^ a;
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        flt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

`ifdef IFETCH_BOUNDS_CHECK_EN
  localparam int NEXP = 32;
`else
  localparam int NEXP = 64;
`endif

  function automatic void add(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc, input logic flt);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.flt = flt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          pops;

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //   rst rv  rpc           rdy req addr          vld pc            flt
    add(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0); // reset state
    add(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0); // IDLE
    add(0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        0); // first request
    add(0, 0, 32'h0,        1, 1, 32'h4,        1, 32'h0,        0);
    add(0, 0, 32'h0,        1, 1, 32'h8,        1, 32'h4,        0);
    add(0, 0, 32'h0,        0, 1, 32'hC,        1, 32'h8,        0); // backpressure
    add(0, 0, 32'h0,        0, 0, 32'h10,       1, 32'h8,        0);
    add(0, 0, 32'h0,        0, 0, 32'h10,       1, 32'h8,        0);
    add(0, 0, 32'h0,        1, 1, 32'h10,       1, 32'h8,        0); // push+pop at full
    add(0, 0, 32'h0,        0, 0, 32'h14,       1, 32'hC,        0);
    add(0, 1, 32'h40,       0, 0, 32'h14,       1, 32'hC,        0); // redirect, full buffer
    add(0, 0, 32'h0,        0, 1, 32'h40,       0, 32'h0,        0);
    add(0, 0, 32'h0,        1, 1, 32'h44,       1, 32'h40,       0);
    add(0, 1, 32'h42,       1, 0, 32'h48,       1, 32'h44,       0); // misaligned
    add(0, 0, 32'h0,        1, 0, 32'h42,       0, 32'h0,        1);
    add(0, 0, 32'h0,        1, 0, 32'h42,       0, 32'h0,        1);
    add(0, 1, 32'h10,       1, 0, 32'h42,       0, 32'h0,        1); // clear fault
    add(0, 0, 32'h0,        1, 1, 32'h10,       0, 32'h0,        0);
    add(0, 0, 32'h0,        1, 1, 32'h14,       1, 32'h10,       0);
    add(0, 0, 32'h0,        0, 1, 32'h18,       1, 32'h14,       0);
    add(1, 0, 32'h0,        0, 0, 32'h1C,       1, 32'h14,       0); // reset, buffer full
    add(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0); // IDLE, ready low x6
    add(0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 1, 32'h4,        1, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 32'h8,        1, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 32'h8,        1, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 32'h8,        1, 32'h0,        0);
    add(0, 0, 32'h0,        1, 1, 32'h8,        1, 32'h0,        0);
    add(0, 0, 32'h0,        1, 1, 32'hC,        1, 32'h4,        0);
    add(0, 0, 32'h0,        1, 1, 32'h10,       1, 32'h8,        0);
`ifdef IFETCH_BOUNDS_CHECK_EN
    add(0, 1, 32'h78,       1, 0, 32'h14,       1, 32'hC,        0);
    add(0, 0, 32'h0,        1, 1, 32'h78,       0, 32'h0,        0);
    add(0, 0, 32'h0,        1, 1, 32'h7C,       1, 32'h78,       0);
    add(0, 0, 32'h0,        1, 0, 32'h80,       1, 32'h7C,       0); // out of range
    add(0, 0, 32'h0,        1, 0, 32'h80,       0, 32'h0,        1);
`else
    add(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h14,      1, 32'hC,        0);
    add(0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h0,       0);
    add(0, 0, 32'h0,        1, 1, 32'h0,        1, 32'hFFFF_FFFC, 0); // PC wrap
    add(0, 0, 32'h0,        1, 1, 32'h4,        1, 32'h0,        0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      if_ready       = vecs[i].rdy;
      #2;
      chk($sformatf("row%0d imem_req", i),    {31'b0, imem_req},    {31'b0, vecs[i].req});
      chk($sformatf("row%0d imem_addr", i),   imem_addr,            vecs[i].addr);
      chk($sformatf("row%0d if_valid", i),    {31'b0, if_valid},    {31'b0, vecs[i].vld});
      chk($sformatf("row%0d if_pc", i),       if_pc,                vecs[i].pc);
      chk($sformatf("row%0d if_instr", i),    if_instr,
          vecs[i].vld ? mem_word(vecs[i].pc) : 32'h0);
      chk($sformatf("row%0d fetch_fault", i), {31'b0, fetch_fault}, {31'b0, vecs[i].flt});
      @(posedge clk);
      #1;
    end

    // Random-backpressure stream from reset, checked against an in-order scoreboard.
    rst = 1'b1; redirect_valid = 1'b0; if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NEXP; k++) exp_q.push_back(32'(k * 4));
    pops = 0;
    for (int c = 0; c < 60; c++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      #2;
      if (if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb unexpected pop pc", if_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb pc", if_pc, e);
          chk("sb instr", if_instr, mem_word(e));
          pops++;
        end
      end
      @(posedge clk);
      #1;
    end
    chk("sb enough pops", {31'b0, pops >= 20}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: drives the instruction-memory read port (`imem_req`/`imem_addr`/`imem_data`) and delivers each fetched instruction with its PC to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage. It owns the program counter, holds up to two fetched words in a flushable buffer, and accepts redirects from execute (branches and jumps). Memory read data is combinational: `imem_data` is valid in the same cycle `imem_req` and `imem_addr` are driven.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `IMEM_BYTES`, 128, instruction memory size in bytes; used only by the bounds check.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  memory read enable.
- `imem_addr`  out  32  byte address; always equals the current PC.
- `imem_data`  in  32  instruction word, valid in the same cycle as `imem_req`.
- `redirect_valid`  in  1  load a new PC (branch or jump taken).
- `redirect_pc`  in  32  target byte address.
- `if_valid`  out  1  buffer head holds an instruction.
- `if_ready`  in  1  decode accepts the head this cycle.
- `if_instr`  out  32  head instruction.
- `if_pc`  out  32  head PC.
- `fetch_fault`  out  1  fetch stopped on a bad address; sticky.

## Operation
- States:
  - `IDLE` is entered from reset and lasts one cycle; it then goes to `RUN`.
  - `RUN` fetches.
  - `FAULT` stops fetching.
- Reset values:
  - `pc` = `RESET_PC`, `imem_addr` = `RESET_PC`.
  - `imem_req` = 0, `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `fetch_fault` = 0.
  - Buffer empty.
- `imem_req` = (state==RUN) && !redirect_valid && (count<2 || (if_valid && if_ready)).
- When `imem_req` is high, on the next edge:
  - push {pc, imem_data} into the buffer;
  - pc <= pc + 4, modulo 2^32 (wraps from FFFF_FFFC to 0).
- Pop: `if_valid && if_ready`. Push and pop in the same cycle with count==2 is legal; count stays 2.
- Output ordering: strict FIFO. When the buffer is empty, `if_instr` and `if_pc` read 0.
- Redirect has the highest priority, in any state:
  - the buffer is flushed (count <= 0) and no push occurs that cycle;
  - a pop handshake in that cycle still completes for decode, but the entry is discarded with the flush.
- Redirect to an aligned target (`redirect_pc[1:0]`==0):
  - pc <= redirect_pc;
  - state <= RUN;
  - `fetch_fault` <= 0.
- Redirect to a misaligned target:
  - state <= FAULT;
  - `fetch_fault` <= 1;
  - pc <= redirect_pc (kept for debug).
- In `FAULT`: no fetches. Already-buffered entries were flushed by the redirect, so `if_valid` stays 0. The state is left only through `rst` or an aligned redirect.
- `rst` asserted at any time, including mid-redirect or with a full buffer, returns every register to its reset value on that edge.

## Timing
- Reset release: edge E0 with rst=0 moves IDLE->RUN.
- Cycle after E0: `imem_req`=1, `imem_addr`=`RESET_PC`.
- `if_valid`=1 from the following cycle onward.
- Sustained throughput is one instruction per cycle while `if_ready`=1.
- Redirect latency, counted from the cycle `redirect_valid` is sampled:
  - +1 cycle: `imem_req` on the target;
  - +2 cycles: `if_valid` with `if_pc`=target.
- Backpressure: with `if_ready`=0, at most 2 instructions are fetched, then `imem_req` drops to 0. The request resumes in the same cycle a pop occurs.
- `fetch_fault` asserts on the edge after the offending redirect or fetch attempt.

## Configuration
- `IFETCH_BOUNDS_CHECK_EN` defined:
  - in `RUN`, if pc + 3 > `IMEM_BYTES`-1, then `imem_req`=0 that cycle;
  - on the next edge, state <= FAULT and `fetch_fault` <= 1;
  - entries already buffered remain poppable.
- `IFETCH_BOUNDS_CHECK_EN` not defined:
  - no range check; any aligned PC is requested;
  - `fetch_fault` comes only from misaligned redirects.

## Structure
- Package `ifetch_pkg` holds:
  - `fetch_state_t` enum {IDLE, RUN, FAULT};
  - `fetch_entry_t` packed struct {pc[31:0], instr[31:0]};
  - `IFETCH_BUF_DEPTH` = 2.
- Sub-module `fetch_buffer` is a 2-entry FIFO of `fetch_entry_t` with push, pop, flush, count, and head outputs. Flush has priority over push.

## Test plan
- Reset release, memory preloaded with 0x00000013 at 0x0 and 0x00100093 at 0x4, `if_ready`=1:
  - `if_pc` sequence 0x0, 0x4, 0x8, … on consecutive cycles;
  - first `if_valid` two cycles after E0.
- `if_ready`=0 for 6 cycles:
  - exactly 2 requests (0x0, 0x4), then `imem_req`=0;
  - after raising `if_ready`, outputs are 0x0, 0x4, 0x8 in order with no loss or duplication.
- Redirect to 0x40 with both buffer entries full:
  - the buffer is flushed;
  - the next request goes to 0x40;
  - the next `if_pc` is 0x40, two cycles after the redirect.
- Redirect to 0x42:
  - `fetch_fault`=1 and stays 1;
  - `imem_req`=0, `if_valid`=0;
  - a later redirect to 0x10 clears the fault and fetches from 0x10.
- With `IFETCH_BOUNDS_CHECK_EN` and `IMEM_BYTES`=128, run sequentially from 0x70:
  - fetches 0x70–0x7C;
  - at 0x80, `imem_req`=0 and then `fetch_fault`=1.
- Reset asserted mid-stream with the buffer full:
  - the next cycle shows `if_valid`=0 and `imem_addr`=`RESET_PC`;
  - fetching restarts normally.
